hazard_scoreboard_unit: RTL and testbench

//  Generalised forwarding and hazard unit for the pipelined RISC-V core with a variable number of

---
 rtl/hazard_pkg.sv | 18 +
 rtl/mc_scoreboard.sv | 93 +++++++++
 rtl/hazard_scoreboard_unit.sv | 91 +++++++++
 tb/tb_hazard_scoreboard_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit and its multi-cycle scoreboard.
//   REG_ADDR_W : architectural register index width
//   FWD_RF     : forward-select encoding meaning "take the register file value"
//   SB_CNT_W   : scoreboard countdown width (covers MC_LAT up to 2**SB_CNT_W-1)
//   sb_entry_t : one scoreboard entry {valid, rd, cnt}
package hazard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int FWD_RF     = 0;
   localparam int SB_CNT_W   = 5;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [SB_CNT_W-1:0]   cnt;
   } sb_entry_t;

endpackage

// File: rtl/mc_scoreboard.sv
// Scoreboard for a fixed-latency multi-cycle unit (MUL/DIV).
// Tracks destination registers of in-flight ops and flags RAW/WAW hazards
// against the D-stage sources and the E-stage destination.
// Ports:
//   clk, rst            clock / async active-low reset
//   mc_issue_e          op dispatched to the multi-cycle unit this cycle
//   regwrite_e, rd_e    E-stage write enable and destination
//   rs_d                D-stage sources, NUM_SRC fields of REG_ADDR_W bits
//   sb_hz               RAW or WAW against a still-counting entry
//   sb_full             every entry valid and none retiring
//   mc_busy             any entry valid
//   mc_overflow         sticky: issue attempted while full
module mc_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int MC_DEPTH = 2,
   parameter int MC_LAT   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mc_issue_e,
   input  logic                          regwrite_e,
   input  logic [REG_ADDR_W-1:0]         rd_e,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
   output logic                          sb_hz,
   output logic                          sb_full,
   output logic                          mc_busy,
   output logic                          mc_overflow
);

   sb_entry_t           ent_q [MC_DEPTH];
   sb_entry_t           ent_d [MC_DEPTH];
   logic                ovf_q, ovf_d;
   logic [MC_DEPTH-1:0] valid_v, live_v, free_v, alloc_oh;
   logic                issue_ok;

   // live = valid and still counting; a valid entry at cnt==0 is in its
   // writeback cycle and is neither a hazard nor free for reuse.
   always_comb begin
      valid_v = '0;
      live_v  = '0;
      for (int i = 0; i < MC_DEPTH; i++) begin
         valid_v[i] = ent_q[i].valid;
         live_v[i]  = ent_q[i].valid && (ent_q[i].cnt != '0);
      end
   end

   assign free_v   = ~valid_v;
   // Isolate the lowest set bit: lowest free entry wins.
   assign alloc_oh = free_v & (~free_v + MC_DEPTH'(1));
   assign sb_full  = &live_v;
   assign issue_ok = mc_issue_e && (rd_e != '0) && !sb_full;

   always_comb begin
      ovf_d = ovf_q | (mc_issue_e & sb_full);
      for (int i = 0; i < MC_DEPTH; i++) begin
         ent_d[i] = '0;
         if (live_v[i]) begin
            ent_d[i]     = ent_q[i];
            ent_d[i].cnt = ent_q[i].cnt - SB_CNT_W'(1);
         end
         if (issue_ok && alloc_oh[i])
            ent_d[i] = '{valid: 1'b1, rd: rd_e, cnt: SB_CNT_W'(MC_LAT - 1)};
      end
   end

   // An op being issued this cycle is the owner of rd_e, so it is not a WAW.
   always_comb begin
      sb_hz = 1'b0;
      for (int e = 0; e < MC_DEPTH; e++) begin
         for (int s = 0; s < NUM_SRC; s++)
            if (live_v[e] && (ent_q[e].rd == rs_d[s*REG_ADDR_W +: REG_ADDR_W]))
               sb_hz = 1'b1;
         if (live_v[e] && regwrite_e && !mc_issue_e && (ent_q[e].rd == rd_e))
            sb_hz = 1'b1;
      end
   end

   assign mc_busy     = |valid_v;
   assign mc_overflow = ovf_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MC_DEPTH; i++) ent_q[i] <= '0;
         ovf_q <= 1'b0;
      end else begin
         ent_q <= ent_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding and hazard unit for the pipelined RISC-V core.
// Selects E-stage operand bypasses, detects load-use and multi-cycle
// scoreboard hazards, and drives the stall/flush controls.
// Ports:
//   clk, rst                 clock / async active-low reset
//   rs_e, rs_d               E/D-stage sources, NUM_SRC fields of 5 bits
//   rd_e, regwrite_e         E-stage destination and write enable
//   is_load_e                E-stage op is a load
//   rd_stg, regwrite_stg     forwarding stages, index 0 = youngest
//   mc_issue_e               E-stage op dispatched to multi-cycle unit
//   branch_taken_e           redirect resolved in E
//   fwd_sel_e                per source: 0 = regfile, k = stage k-1
//   stall_f, stall_d         hold PC / F-D register
//   flush_d, flush_e         clear F-D register / bubble into D-E register
//   mc_busy, mc_overflow     scoreboard occupancy / sticky overflow
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int NUM_FWD  = 2,
   parameter int MC_DEPTH = 2,
   parameter int MC_LAT   = 4,
   parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_e,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
   input  logic [REG_ADDR_W-1:0]         rd_e,
   input  logic                          regwrite_e,
   input  logic                          is_load_e,
   input  logic [NUM_FWD*REG_ADDR_W-1:0] rd_stg,
   input  logic [NUM_FWD-1:0]            regwrite_stg,
   input  logic                          mc_issue_e,
   input  logic                          branch_taken_e,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_e,
   output logic                          stall_f,
   output logic                          stall_d,
   output logic                          flush_d,
   output logic                          flush_e,
   output logic                          mc_busy,
   output logic                          mc_overflow
);

   logic lu_hz, sb_hz, sb_full, hold;

   // Scan oldest to youngest so the youngest matching stage overwrites.
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
      logic [SEL_W-1:0] sel;
      always_comb begin
         sel = SEL_W'(FWD_RF);
         for (int k = NUM_FWD - 1; k >= 0; k--)
            if (regwrite_stg[k] && (rd_stg[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                (rd_stg[k*REG_ADDR_W +: REG_ADDR_W] == rs_e[s*REG_ADDR_W +: REG_ADDR_W]))
               sel = SEL_W'(k + 1);
      end
      assign fwd_sel_e[s*SEL_W +: SEL_W] = sel;
   end

   always_comb begin
      lu_hz = 1'b0;
      if (is_load_e && regwrite_e && (rd_e != '0))
         for (int s = 0; s < NUM_SRC; s++)
            if (rs_d[s*REG_ADDR_W +: REG_ADDR_W] == rd_e) lu_hz = 1'b1;
   end

   mc_scoreboard #(
      .NUM_SRC  (NUM_SRC),
      .MC_DEPTH (MC_DEPTH),
      .MC_LAT   (MC_LAT)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .mc_issue_e  (mc_issue_e),
      .regwrite_e  (regwrite_e),
      .rd_e        (rd_e),
      .rs_d        (rs_d),
      .sb_hz       (sb_hz),
      .sb_full     (sb_full),
      .mc_busy     (mc_busy),
      .mc_overflow (mc_overflow)
   );

   // A full-scoreboard stall holds the issuing op in E rather than bubbling it.
   assign hold    = lu_hz | sb_hz | (sb_full & mc_issue_e);
   assign stall_f = hold;
   assign stall_d = hold;
   assign flush_e = lu_hz | sb_hz | branch_taken_e;
   assign flush_d = branch_taken_e;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

   localparam int NS = 2, NF = 2, MD = 2, ML = 4, SW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NS*5-1:0]   rs_e, rs_d;
   logic [4:0]        rd_e;
   logic              regwrite_e, is_load_e, mc_issue_e, branch_taken_e;
   logic [NF*5-1:0]   rd_stg;
   logic [NF-1:0]     regwrite_stg;
   logic [NS*SW-1:0]  fwd_sel_e;
   logic              stall_f, stall_d, flush_d, flush_e, mc_busy, mc_overflow;

   int n_chk  = 0;
   int n_fail = 0;

   hazard_scoreboard_unit #(
      .NUM_SRC(NS), .NUM_FWD(NF), .MC_DEPTH(MD), .MC_LAT(ML)
   ) dut (
      .clk(clk), .rst(rst), .rs_e(rs_e), .rs_d(rs_d), .rd_e(rd_e),
      .regwrite_e(regwrite_e), .is_load_e(is_load_e), .rd_stg(rd_stg),
      .regwrite_stg(regwrite_stg), .mc_issue_e(mc_issue_e),
      .branch_taken_e(branch_taken_e), .fwd_sel_e(fwd_sel_e),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .mc_busy(mc_busy), .mc_overflow(mc_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each slot remembers the absolute cycle of its op's writeback. Between
   // issue and writeback the op is a hazard; in the writeback cycle it only
   // occupies its slot.
   bit m_busy [MD];
   int m_rd   [MD];
   int m_wb   [MD];
   int mcyc = 0;
   bit m_ovf = 0;

   function automatic bit pending(input int i);
      return m_busy[i] && (mcyc < m_wb[i]);
   endfunction

   function automatic bit model_full();
      bit f = 1;
      for (int i = 0; i < MD; i++) if (!pending(i)) f = 0;
      return f;
   endfunction

   initial forever begin : model
      bit full;
      int alloc;
      @(posedge clk or negedge rst);
      if (!rst) begin
         for (int i = 0; i < MD; i++) m_busy[i] = 0;
         m_ovf = 0;
      end else begin
         full  = model_full();
         alloc = -1;
         if (mc_issue_e && full) m_ovf = 1;
         if (mc_issue_e && rd_e != 0 && !full)
            for (int i = 0; i < MD; i++) if (!m_busy[i] && alloc < 0) alloc = i;
         for (int i = 0; i < MD; i++) if (m_busy[i] && mcyc == m_wb[i]) m_busy[i] = 0;
         if (alloc >= 0) begin
            m_busy[alloc] = 1;
            m_rd[alloc]   = int'(rd_e);
            m_wb[alloc]   = mcyc + ML;
         end
         mcyc++;
      end
   end

   always @(negedge clk) begin : cmp
      logic [NS*SW-1:0] e_fwd;
      bit e_lu, e_sb, e_busy, e_hold;
      e_fwd = '0;
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < NF; k++)
            if (regwrite_stg[k] && rd_stg[k*5 +: 5] != 0 && rd_stg[k*5 +: 5] == rs_e[s*5 +: 5]) begin
               e_fwd[s*SW +: SW] = SW'(k + 1);
               break;
            end
      e_lu = 0;
      for (int s = 0; s < NS; s++)
         if (is_load_e && regwrite_e && rd_e != 0 && rs_d[s*5 +: 5] == rd_e) e_lu = 1;
      e_sb = 0;
      e_busy = 0;
      for (int i = 0; i < MD; i++) begin
         if (m_busy[i]) e_busy = 1;
         if (pending(i)) begin
            for (int s = 0; s < NS; s++) if (int'(rs_d[s*5 +: 5]) == m_rd[i]) e_sb = 1;
            if (regwrite_e && !mc_issue_e && int'(rd_e) == m_rd[i]) e_sb = 1;
         end
      end
      e_hold = e_lu | e_sb | (model_full() & mc_issue_e);
      check("m_fwd_sel", 32'(fwd_sel_e), 32'(e_fwd));
      check("m_stall_f", 32'(stall_f), 32'(e_hold));
      check("m_stall_d", 32'(stall_d), 32'(e_hold));
      check("m_flush_e", 32'(flush_e), 32'(e_lu | e_sb | branch_taken_e));
      check("m_flush_d", 32'(flush_d), 32'(branch_taken_e));
      check("m_busy",    32'(mc_busy), 32'(e_busy));
      check("m_ovf",     32'(mc_overflow), 32'(m_ovf));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs_e = '0; rs_d = '0; rd_e = '0; regwrite_e = 0; is_load_e = 0;
      rd_stg = '0; regwrite_stg = '0; mc_issue_e = 0; branch_taken_e = 0;
   endtask

   task automatic fwd_case(input string nm, input logic [9:0] rs, input logic [9:0] rd,
                           input logic [1:0] we, input logic [3:0] exp);
      rs_e = rs; rd_stg = rd; regwrite_stg = we;
      #1;
      check(nm, 32'(fwd_sel_e), 32'(exp));
   endtask

   task automatic issue(input logic [4:0] rd);
      mc_issue_e = 1; regwrite_e = 1; rd_e = rd;
   endtask

   initial begin
      idle();
      #2;
      check("rst_busy", 32'(mc_busy), 0);
      check("rst_ovf", 32'(mc_overflow), 0);
      fwd_case("rst_fwd_comb", {5'd0, 5'd5}, {5'd5, 5'd5}, 2'b11, 4'b0001);
      tick();
      rst = 1;
      tick();

      // forwarding priority
      fwd_case("fwd_both",  {5'd0, 5'd5}, {5'd5, 5'd5}, 2'b11, 4'b0001);
      fwd_case("fwd_stg1",  {5'd0, 5'd5}, {5'd5, 5'd5}, 2'b10, 4'b0010);
      fwd_case("fwd_x0",    {5'd0, 5'd0}, {5'd0, 5'd0}, 2'b11, 4'b0000);
      fwd_case("fwd_mix",   {5'd6, 5'd5}, {5'd6, 5'd5}, 2'b11, 4'b1001);
      fwd_case("fwd_nowe",  {5'd6, 5'd5}, {5'd6, 5'd5}, 2'b00, 4'b0000);
      tick();
      idle();

      // load-use: one cycle, then the load has left E
      is_load_e = 1; regwrite_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd0};
      #1;
      check("lu_stall_f", 32'(stall_f), 1);
      check("lu_flush_e", 32'(flush_e), 1);
      check("lu_flush_d", 32'(flush_d), 0);
      tick();
      is_load_e = 0; regwrite_e = 0; rd_e = 0;
      #1;
      check("lu_release", 32'(stall_d), 0);
      is_load_e = 1; regwrite_e = 1; rd_e = 0; rs_d = '0;
      #1;
      check("lu_x0", 32'(stall_f), 0);
      tick();
      idle();

      // MC x9: dependent stalls three cycles, busy for four
      issue(5'd9);
      tick();
      idle();
      rs_d = {5'd0, 5'd9};
      for (int c = 0; c < 4; c++) begin
         #1;
         check($sformatf("mc_stall_c%0d", c), 32'(stall_f), (c < 3) ? 1 : 0);
         check($sformatf("mc_busy_c%0d", c), 32'(mc_busy), 1);
         tick();
      end
      check("mc_busy_fall", 32'(mc_busy), 0);
      idle();

      // issue into the free entry while the other retires
      issue(5'd13);
      tick();
      idle();
      repeat (3) tick();
      issue(5'd14);
      #1;
      check("rr_no_stall", 32'(stall_f), 0);
      tick();
      idle();
      rs_d = {5'd0, 5'd14};
      #1;
      check("rr_new_hz", 32'(stall_f), 1);
      check("rr_ovf", 32'(mc_overflow), 0);
      rs_d = {5'd0, 5'd13};
      #1;
      check("rr_old_gone", 32'(stall_f), 0);
      repeat (5) tick();
      check("rr_drained", 32'(mc_busy), 0);
      idle();

      // branch during sb stall, WAW, then reset mid-countdown
      issue(5'd15);
      tick();
      idle();
      rs_d = {5'd0, 5'd15}; branch_taken_e = 1;
      #1;
      check("br_stall", 32'(stall_f), 1);
      check("br_flush_d", 32'(flush_d), 1);
      check("br_flush_e", 32'(flush_e), 1);
      tick();
      idle();
      regwrite_e = 1; rd_e = 5'd15;
      #1;
      check("waw_stall", 32'(stall_d), 1);
      mc_issue_e = 1;
      #1;
      check("waw_issue_ok", 32'(stall_d), 0);
      mc_issue_e = 0;
      rst = 0;
      #1;
      check("rst_mid_busy", 32'(mc_busy), 0);
      check("rst_mid_stall", 32'(stall_f), 0);
      tick();
      rst = 1;
      idle();
      tick();

      // fill both entries, third issue stalls and overflows
      issue(5'd10);
      tick();
      issue(5'd11);
      tick();
      issue(5'd12);
      #1;
      check("full_stall", 32'(stall_f), 1);
      check("full_no_flush", 32'(flush_e), 0);
      check("full_ovf_pre", 32'(mc_overflow), 0);
      tick();
      idle();
      #1;
      check("full_ovf_set", 32'(mc_overflow), 1);
      repeat (6) tick();
      check("ovf_sticky", 32'(mc_overflow), 1);
      check("full_drained", 32'(mc_busy), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
